seg_time_display: RTL and testbench
===================================

// Module: seg_time_display
// PURPOSE
//  Downstream of the countdown timer: consumes its minute/tens/units BCD digits and time_out pulse,
//  drives the 4-digit common-anode seven-segment display as "M.SS" by time-multiplexed scanning.
//  Digits are frame-latched so a digit change mid-scan never tears; time_out blinks the whole display.
// PARAMETERS
//  REFRESH_DIV  100000      clk_in cycles each digit is lit (1 kHz/digit at 100 MHz)
//  BLINK_DIV    25000000    clk_in cycles per blink half-period (0.25 s at 100 MHz)
//  BLINK_COUNT  6           half-periods per blink burst (3 off/on pairs); >= 1
// PORTS
//  clk_in      in   1  system clock; all logic on rising edge
//  reset       in   1  asynchronous, active-high; clears all state
//  min_digit   in   4  minutes digit (BCD), synchronous to clk_in
//  tens_digit  in   4  tens-of-seconds digit (BCD)
//  ones_digit  in   4  units-of-seconds digit (BCD)
//  time_out    in   1  timer expiry level; rising edge starts a blink burst
//  seg         out  7  segments {g,f,e,d,c,b,a}, active-low
//  dp          out  1  decimal point, active-low
//  an          out  4  anode enables, active-low; an[0] = rightmost digit
// BEHAVIOUR
//  Reset (async): an=4'b1111, seg=7'b1111111, dp=1; refresh_cnt=0, scan_idx=0, shadow digits=0,
//   blink_left=0, blink_cnt=0, time_out_q=0. Outputs registered: 1-cycle latency from scan state.
//  Refresh: refresh_cnt counts 0..REFRESH_DIV-1; at terminal count wraps to 0, scan_idx += 1 mod 4.
//  Scan map: idx0 -> an=1110 ones; idx1 -> an=1101 tens; idx2 -> an=1011 minutes, dp=0;
//   idx3 -> an=1111 (leftmost digit unused, blank). dp=1 on all other indices.
//  Frame latch: shadow digits load from inputs only on the cycle scan_idx wraps 3->0;
//   first frame after reset displays 0.00. Input changes mid-frame appear next frame.
//  Decode: 0-9 standard patterns (0 -> 7'b1000000, 8 -> 7'b0000000); values 10-15 -> dash 7'b0111111.
//  Blink FSM states: SHOW, BLINK_OFF, BLINK_ON.
//   time_out_q registers time_out; edge = time_out & ~time_out_q.
//   SHOW --edge--> BLINK_OFF, blink_left=BLINK_COUNT, blink_cnt=0.
//   In BLINK_*: blink_cnt counts 0..BLINK_DIV-1; at terminal count blink_left -= 1 and state
//    toggles OFF<->ON; when blink_left reaches 0, go to SHOW.
//   BLINK_OFF forces an=1111, dp=1 (scan counters keep running); BLINK_ON/SHOW display normally.
//   Edge during a burst restarts it (BLINK_OFF, full count). time_out held high: one burst only.
//   Edge and refresh terminal count in same cycle: both take effect independently.
//  Reset mid-scan or mid-burst: immediate return to reset values; no partial burst resumes.
//  Widths: refresh_cnt = $clog2(REFRESH_DIV), blink_cnt = $clog2(BLINK_DIV),
//   blink_left = $clog2(BLINK_COUNT+1); no counter may overflow for any legal parameter.
// STRUCTURE
//  Shared header seg_defs.vh: segment pattern localparams (SEG_0..SEG_9, SEG_DASH, SEG_BLANK),
//   anode one-hot constants, blink state encodings.
//  One sub-module: seg_decoder (4-bit BCD -> 7-bit active-low pattern, combinational).
//  Top holds refresh counter, scan index, shadow registers, blink FSM, output registers.
// TESTING (REFRESH_DIV=4, BLINK_DIV=8, BLINK_COUNT=2 for sim)
//  Reset release, digits 1/2/3 -> frame 1 shows 0.00; from frame 2 an cycles 1110,1101,1011,1111
//   every 4 clks with seg SEG_3, SEG_2, SEG_1 (dp=0 on an=1011), blank.
//  Change ones_digit 3->7 while scan_idx=1 -> idx0 of the current frame unaffected; SEG_7 first on next frame.
//  ones_digit=4'hC -> SEG_DASH on an=1110.
//  time_out 0->1 and held -> an=1111 for 8 clks, normal 8 clks, then SHOW; no second burst while held.
//  Second time_out edge 5 clks into BLINK_ON -> burst restarts with 8 clks dark.
//  Assert reset mid-burst at scan_idx=2 -> outputs 1111/1111111/1 same cycle (async), all counters 0.

Source files
------------

// File: rtl/seg_time_display_pkg.sv
// Shared constants for the seven-segment time display: segment patterns,
// anode selects, blink FSM encoding and a counter-width helper.
package seg_time_display_pkg;

  // Segment order {g,f,e,d,c,b,a}, active-low.
  localparam logic [6:0] SEG_0     = 7'b1000000;
  localparam logic [6:0] SEG_1     = 7'b1111001;
  localparam logic [6:0] SEG_2     = 7'b0100100;
  localparam logic [6:0] SEG_3     = 7'b0110000;
  localparam logic [6:0] SEG_4     = 7'b0011001;
  localparam logic [6:0] SEG_5     = 7'b0010010;
  localparam logic [6:0] SEG_6     = 7'b0000010;
  localparam logic [6:0] SEG_7     = 7'b1111000;
  localparam logic [6:0] SEG_8     = 7'b0000000;
  localparam logic [6:0] SEG_9     = 7'b0010000;
  localparam logic [6:0] SEG_DASH  = 7'b0111111;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  localparam logic [3:0] AN_ONES = 4'b1110;
  localparam logic [3:0] AN_TENS = 4'b1101;
  localparam logic [3:0] AN_MIN  = 4'b1011;
  localparam logic [3:0] AN_OFF  = 4'b1111;

  typedef enum logic [1:0] {
    SHOW      = 2'd0,
    BLINK_OFF = 2'd1,
    BLINK_ON  = 2'd2
  } blink_state_t;

  // Bits needed to hold 0..n-1, never less than one.
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/seg_time_display_decoder.sv
// BCD digit to active-low seven-segment pattern; non-decimal codes show a dash.
module seg_time_display_decoder
  import seg_time_display_pkg::*;
(
  input  logic [3:0] i_bcd,
  output logic [6:0] o_seg
);

  always_comb begin
    case (i_bcd)
      4'd0:    o_seg = SEG_0;
      4'd1:    o_seg = SEG_1;
      4'd2:    o_seg = SEG_2;
      4'd3:    o_seg = SEG_3;
      4'd4:    o_seg = SEG_4;
      4'd5:    o_seg = SEG_5;
      4'd6:    o_seg = SEG_6;
      4'd7:    o_seg = SEG_7;
      4'd8:    o_seg = SEG_8;
      4'd9:    o_seg = SEG_9;
      default: o_seg = SEG_DASH;
    endcase
  end

endmodule

// File: rtl/seg_time_display.sv
// Scans the countdown digits onto a 4-digit common-anode display as "M.SS",
// latching digits once per frame and blinking the display on timer expiry.
module seg_time_display
  import seg_time_display_pkg::*;
#(
  parameter int unsigned REFRESH_DIV = 100000,
  parameter int unsigned BLINK_DIV   = 25000000,
  parameter int unsigned BLINK_COUNT = 6
) (
  input  logic       clk_in,
  input  logic       reset,
  input  logic [3:0] min_digit,
  input  logic [3:0] tens_digit,
  input  logic [3:0] ones_digit,
  input  logic       time_out,
  output logic [6:0] seg,
  output logic       dp,
  output logic [3:0] an
);

  localparam int unsigned RW = cnt_width(REFRESH_DIV);
  localparam int unsigned BW = cnt_width(BLINK_DIV);
  localparam int unsigned LW = cnt_width(BLINK_COUNT + 1);

  localparam logic [RW-1:0] REFRESH_LAST = RW'(REFRESH_DIV - 1);
  localparam logic [BW-1:0] BLINK_LAST   = BW'(BLINK_DIV - 1);
  localparam logic [LW-1:0] BLINK_FULL   = LW'(BLINK_COUNT);

  logic [RW-1:0] r_refresh_cnt;
  logic [1:0]    r_scan_idx;
  logic [3:0]    r_min, r_tens, r_ones;
  logic          r_time_out_q;
  blink_state_t  r_state;
  logic [BW-1:0] r_blink_cnt;
  logic [LW-1:0] r_blink_left;

  logic          w_refresh_tc;
  logic          w_frame_end;
  logic          w_edge;
  logic [3:0]    w_digit;
  logic [6:0]    w_seg_dec;
  blink_state_t  w_state_nxt;
  logic [BW-1:0] w_blink_cnt_nxt;
  logic [LW-1:0] w_blink_left_nxt;
  logic [3:0]    w_an_nxt;
  logic [6:0]    w_seg_nxt;
  logic          w_dp_nxt;

  assign w_refresh_tc = (r_refresh_cnt == REFRESH_LAST);
  assign w_frame_end  = w_refresh_tc && (r_scan_idx == 2'd3);
  assign w_edge       = time_out & ~r_time_out_q;

  // NOTE: sequential state uses nonblocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk_in or posedge reset) begin
    if (reset) begin
      r_refresh_cnt <= '0;
      r_scan_idx    <= 2'd0;
      r_min         <= 4'd0;
      r_tens        <= 4'd0;
      r_ones        <= 4'd0;
    end else begin
      r_refresh_cnt <= w_refresh_tc ? '0 : r_refresh_cnt + RW'(1);
      if (w_refresh_tc) r_scan_idx <= r_scan_idx + 2'd1;
      // Latch a whole frame at once so mid-scan digit changes never tear.
      if (w_frame_end) begin
        r_min  <= min_digit;
        r_tens <= tens_digit;
        r_ones <= ones_digit;
      end
    end
  end

  always_ff @(posedge clk_in or posedge reset) begin
    if (reset) begin
      r_time_out_q <= 1'b0;
      r_state      <= SHOW;
      r_blink_cnt  <= '0;
      r_blink_left <= '0;
    end else begin
      r_time_out_q <= time_out;
      r_state      <= w_state_nxt;
      r_blink_cnt  <= w_blink_cnt_nxt;
      r_blink_left <= w_blink_left_nxt;
    end
  end

  // NOTE: every always_comb output gets a default first, so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    w_state_nxt      = r_state;
    w_blink_cnt_nxt  = r_blink_cnt;
    w_blink_left_nxt = r_blink_left;
    if (w_edge) begin
      w_state_nxt      = BLINK_OFF;
      w_blink_cnt_nxt  = '0;
      w_blink_left_nxt = BLINK_FULL;
    end else if (r_state != SHOW) begin
      if (r_blink_cnt == BLINK_LAST) begin
        w_blink_cnt_nxt  = '0;
        w_blink_left_nxt = r_blink_left - LW'(1);
        if (r_blink_left == LW'(1))    w_state_nxt = SHOW;
        else if (r_state == BLINK_OFF) w_state_nxt = BLINK_ON;
        else                           w_state_nxt = BLINK_OFF;
      end else begin
        w_blink_cnt_nxt = r_blink_cnt + BW'(1);
      end
    end
  end

  always_comb begin
    case (r_scan_idx)
      2'd0:    w_digit = r_ones;
      2'd1:    w_digit = r_tens;
      default: w_digit = r_min;
    endcase
  end

  seg_time_display_decoder u_decoder (
    .i_bcd (w_digit),
    .o_seg (w_seg_dec)
  );

  always_comb begin
    w_seg_nxt = w_seg_dec;
    w_dp_nxt  = 1'b1;
    case (r_scan_idx)
      2'd0: w_an_nxt = AN_ONES;
      2'd1: w_an_nxt = AN_TENS;
      2'd2: begin
        w_an_nxt = AN_MIN;
        w_dp_nxt = 1'b0;
      end
      default: begin
        w_an_nxt  = AN_OFF;
        w_seg_nxt = SEG_BLANK;
      end
    endcase
    // Dark phase of a blink; scanning continues underneath.
    if (r_state == BLINK_OFF) begin
      w_an_nxt = AN_OFF;
      w_dp_nxt = 1'b1;
    end
  end

  always_ff @(posedge clk_in or posedge reset) begin
    if (reset) begin
      an  <= AN_OFF;
      seg <= SEG_BLANK;
      dp  <= 1'b1;
    end else begin
      an  <= w_an_nxt;
      seg <= w_seg_nxt;
      dp  <= w_dp_nxt;
    end
  end

endmodule

// File: tb/tb_seg_time_display.sv
// Directed bench for seg_time_display with small refresh/blink dividers;
// expected values are hand-derived from the cycle count since reset release.
module tb_seg_time_display;

  localparam logic [6:0] P0    = 7'b1000000;
  localparam logic [6:0] P1    = 7'b1111001;
  localparam logic [6:0] P2    = 7'b0100100;
  localparam logic [6:0] P3    = 7'b0110000;
  localparam logic [6:0] P7    = 7'b1111000;
  localparam logic [6:0] PDASH = 7'b0111111;
  localparam logic [6:0] PBLNK = 7'b1111111;

  logic       clk_in;
  logic       reset;
  logic [3:0] min_digit, tens_digit, ones_digit;
  logic       time_out;
  logic [6:0] seg;
  logic       dp;
  logic [3:0] an;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  seg_time_display #(
    .REFRESH_DIV (4),
    .BLINK_DIV   (8),
    .BLINK_COUNT (2)
  ) dut (
    .clk_in     (clk_in),
    .reset      (reset),
    .min_digit  (min_digit),
    .tens_digit (tens_digit),
    .ones_digit (ones_digit),
    .time_out   (time_out),
    .seg        (seg),
    .dp         (dp),
    .an         (an)
  );

  initial clk_in = 1'b0;
  always #5 clk_in = ~clk_in;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %b expected %b (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic check_out(input string tag, input logic [3:0] ea,
                           input logic [6:0] es, input logic ed);
    check({tag, "_an"},  8'(an),  8'(ea));
    check({tag, "_seg"}, 8'(seg), 8'(es));
    check({tag, "_dp"},  8'(dp),  8'(ed));
  endtask

  task automatic check_dark(input string tag);
    check({tag, "_an"}, 8'(an), 8'(4'b1111));
    check({tag, "_dp"}, 8'(dp), 8'(1'b1));
  endtask

  // One rising edge, then park on the following falling edge.
  task automatic tick();
    @(posedge clk_in);
    cyc++;
    @(negedge clk_in);
  endtask

  task automatic goto(input int n);
    while (cyc < n) tick();
  endtask

  initial begin
    reset      = 1'b1;
    min_digit  = 4'd1;
    tens_digit = 4'd2;
    ones_digit = 4'd3;
    time_out   = 1'b0;
    repeat (3) @(negedge clk_in);
    check_out("reset", 4'b1111, PBLNK, 1'b1);
    reset = 1'b0;
    cyc   = 0;

    // Frame 1 shows the cleared shadow digits: 0.00
    goto(1);  check_out("f1_ones", 4'b1110, P0, 1'b1);
    goto(5);  check_out("f1_tens", 4'b1101, P0, 1'b1);
    goto(9);  check_out("f1_min",  4'b1011, P0, 1'b0);
    goto(13); check_out("f1_blnk", 4'b1111, PBLNK, 1'b1);

    // Frame 2 shows the latched inputs 1.23
    goto(17); check_out("f2_ones", 4'b1110, P3, 1'b1);
    goto(21); check_out("f2_tens", 4'b1101, P2, 1'b1);
    goto(25); check_out("f2_min",  4'b1011, P1, 1'b0);
    goto(29); check_out("f2_blnk", 4'b1111, PBLNK, 1'b1);

    // Mid-frame change only shows up on the next frame
    goto(33); check_out("f3_ones", 4'b1110, P3, 1'b1);
    goto(37); check_out("f3_tens", 4'b1101, P2, 1'b1);
    ones_digit = 4'd7;
    goto(45); check_out("f3_blnk", 4'b1111, PBLNK, 1'b1);
    goto(49); check_out("f4_ones7", 4'b1110, P7, 1'b1);

    ones_digit = 4'hC;
    goto(53); check_out("f4_tens", 4'b1101, P2, 1'b1);
    goto(65); check_out("dash", 4'b1110, PDASH, 1'b1);

    // Blink burst: edge at posedge 73, dark outputs 74..81, normal 82..89
    goto(72); time_out = 1'b1;
    goto(73); check_out("pre_blink", 4'b1011, P1, 1'b0);
    goto(74); check_dark("dark_first");
    goto(81); check_dark("dark_last");
    goto(82); check_out("on_first", 4'b1110, PDASH, 1'b1);
    goto(89); check_out("on_last", 4'b1011, P1, 1'b0);
    goto(97); check_out("held_show", 4'b1110, PDASH, 1'b1);
    goto(102); check_out("held_show2", 4'b1101, P2, 1'b1);

    // New burst, then a second edge 5 clocks into its on phase restarts it
    time_out = 1'b0;
    goto(104); time_out = 1'b1;
    goto(106); check_dark("b2_dark");
    goto(110); time_out = 1'b0;
    goto(117); time_out = 1'b1;
    goto(118); check_out("b2_on", 4'b1101, P2, 1'b1);
    goto(119); check_dark("restart_dark");
    goto(122); check_dark("restart_dark_mid");
    goto(124); check_dark("restart_dark_end");
    goto(129); check_out("restart_on", 4'b1110, PDASH, 1'b1);

    // Reset in the dark phase with scan index 2
    goto(130); time_out = 1'b0;
    goto(131); time_out = 1'b1;
    goto(137); check_dark("b3_dark");
    check("b3_scan_idx", 8'(dut.r_scan_idx), 8'd2);
    #1 reset = 1'b1;
    #1;
    check_out("async_rst", 4'b1111, PBLNK, 1'b1);
    check("rst_refresh", 8'(dut.r_refresh_cnt), 8'd0);
    check("rst_scan",    8'(dut.r_scan_idx),    8'd0);
    check("rst_bcnt",    8'(dut.r_blink_cnt),   8'd0);
    check("rst_bleft",   8'(dut.r_blink_left),  8'd0);
    check("rst_state",   8'(dut.r_state),       8'd0);
    check("rst_ones",    8'(dut.r_ones),        8'd0);
    time_out = 1'b0;
    @(negedge clk_in);
    reset = 1'b0;
    cyc   = 0;
    goto(1);  check_out("post_ones", 4'b1110, P0, 1'b1);
    goto(5);  check_out("post_tens", 4'b1101, P0, 1'b1);
    goto(9);  check_out("post_min",  4'b1011, P0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
